// File: rtl/cr_xp10_decomp_be_tlvp_mux_pkg.sv
// Shared types and constants for the XP10 decompressor back-end TLV packer.
package cr_xp10_decomp_be_tlvp_mux_pkg;

  typedef enum logic [0:0] {StIdle, StXfer} tlvp_state_e;

  localparam int unsigned PRIO_RR     = 0;
  localparam int unsigned PRIO_STRICT = 1;

  // FIFO entries are {sot, eot, data}; modules declare the struct at their own DATA_W.
  function automatic int unsigned entry_width(input int unsigned data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/cr_xp10_decomp_be_tlvp_fifo.sv
// Single-clock per-channel FIFO with full/almost-full/empty flags and sticky overflow.
module cr_xp10_decomp_be_tlvp_fifo #(
  parameter int unsigned WIDTH     = 66,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_VAL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             afull,
  output logic             empty,
  output logic             ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt  = CW'(DEPTH);
  localparam logic [CW-1:0] AfullCnt = CW'(DEPTH - AFULL_VAL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             ovf_q;
  logic             push, pop;

  assign full  = (count_q == FullCnt);
  assign afull = (count_q >= AfullCnt);
  assign empty = (count_q == '0);
  assign ovf   = ovf_q;
  assign rdata = mem_q[rptr_q];

  // Full comes from the registered count, so a same-cycle pop never makes room.
  assign push = wr & ~full;
  assign pop  = rd & ~empty;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (wr && full) ovf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/cr_xp10_decomp_be_tlvp_mux.sv
// Merges N_CH buffered TLV streams into one AXI4-stream output with a frame-atomic arbiter.
module cr_xp10_decomp_be_tlvp_mux
  import cr_xp10_decomp_be_tlvp_mux_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_VAL = 4,
  parameter int unsigned PRIO_MODE = 0,
  localparam int unsigned CH_W     = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        ch_wr,
  input  logic [N_CH-1:0]        ch_sot,
  input  logic [N_CH-1:0]        ch_eot,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  output logic [N_CH-1:0]        ch_full,
  output logic [N_CH-1:0]        ch_afull,
  output logic [N_CH-1:0]        ch_ovf,
  output logic                   ob_tvalid,
  input  logic                   ob_tready,
  output logic [DATA_W-1:0]      ob_tdata,
  output logic                   ob_tlast,
  output logic                   ob_tuser,
  output logic [CH_W-1:0]        ob_tid
);

  typedef struct packed {
    logic              sot;
    logic              eot;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int unsigned EW = entry_width(DATA_W);

  entry_t            wr_entry [N_CH];
  entry_t            head     [N_CH];
  logic [N_CH-1:0]   empty, rd;

  tlvp_state_e       state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [CH_W-1:0]   sel_ch, pop_ch;
  logic              sel_vld, pop, out_free;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_entry[i] = '{sot: ch_sot[i], eot: ch_eot[i], data: ch_data[i*DATA_W +: DATA_W]};
    assign rd[i]       = pop && (pop_ch == CH_W'(i));

    cr_xp10_decomp_be_tlvp_fifo #(
      .WIDTH    (EW),
      .DEPTH    (DEPTH),
      .AFULL_VAL(AFULL_VAL)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .wr   (ch_wr[i]),
      .wdata(wr_entry[i]),
      .rd   (rd[i]),
      .rdata(head[i]),
      .full (ch_full[i]),
      .afull(ch_afull[i]),
      .empty(empty[i]),
      .ovf  (ch_ovf[i])
    );
  end

  assign out_free = ~ob_tvalid | ob_tready;

  // Scan from the far end so the last hit is the highest-priority candidate.
  always_comb begin
    int              idx;
    logic [CH_W-1:0] cand;
    sel_vld = 1'b0;
    sel_ch  = '0;
    idx     = 0;
    cand    = '0;
    for (int k = N_CH; k >= 1; k--) begin
      if (PRIO_MODE == PRIO_STRICT) idx = k - 1;
      else                          idx = (int'(last_grant_q) + k) % int'(N_CH);
      cand = CH_W'(idx);
      if (!empty[cand]) begin
        sel_vld = 1'b1;
        sel_ch  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pop          = 1'b0;
    pop_ch       = grant_q;
    case (state_q)
      StIdle: begin
        if (sel_vld && out_free) begin
          pop     = 1'b1;
          pop_ch  = sel_ch;
          grant_d = sel_ch;
          if (head[sel_ch].eot) last_grant_d = sel_ch;
          else                  state_d      = StXfer;
        end
      end
      StXfer: begin
        // Grant is held across a source stall; no other channel may interleave.
        if (out_free && !empty[grant_q]) begin
          pop = 1'b1;
          if (head[grant_q].eot) begin
            state_d      = StIdle;
            last_grant_d = grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= CH_W'(N_CH - 1);
      ob_tvalid    <= 1'b0;
      ob_tdata     <= '0;
      ob_tlast     <= 1'b0;
      ob_tuser     <= 1'b0;
      ob_tid       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      if (pop) begin
        ob_tvalid <= 1'b1;
        ob_tdata  <= head[pop_ch].data;
        ob_tlast  <= head[pop_ch].eot;
        ob_tuser  <= head[pop_ch].sot;
        ob_tid    <= pop_ch;
      end else if (out_free) begin
        ob_tvalid <= 1'b0;
      end
    end
  end

endmodule
